// File: rtl/fg_design.sv
// Sequential factorial generator: one multiply per clock, low 32 bits of N!
// with a sticky overflow flag and a start/busy/done handshake.
module fg_design (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  N,
    output logic [31:0] FACT,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start; FACT/ovf hold the last result
    // CALC  | multiplying acc by cnt down to 2, then publishing the result
    typedef enum logic {IDLE, CALC} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_acc_q, ovf_acc_d;
    logic [31:0] fact_q, fact_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [35:0] prod;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        fact_d    = fact_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        prod      = {4'b0000, acc_q} * {32'd0, cnt_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = 32'd1;
                    cnt_d     = N;
                    ovf_acc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cnt_q <= 4'd1) begin
                    fact_d  = acc_q;
                    ovf_d   = ovf_acc_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    // acc stays exact until the first carry into bit 32; the flag then sticks
                    acc_d     = prod[31:0];
                    ovf_acc_d = ovf_acc_q | (|prod[35:32]);
                    cnt_d     = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= 32'd1;
            cnt_q     <= 4'd0;
            ovf_acc_q <= 1'b0;
            fact_q    <= 32'd0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            fact_q    <= fact_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign FACT = fact_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_fg_design.sv
// Bench for fg_design: a cycle-level behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fg_design;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  N;
    logic [31:0] FACT;
    logic        ovf;
    logic        busy;
    logic        done;

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;
    int done_cnt = 0;

    // model state
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_fact = 32'd0;
    logic        m_ovf  = 1'b0;
    int          m_end  = 0;
    logic [31:0] m_pend_fact = 32'd0;
    logic        m_pend_ovf  = 1'b0;

    longint unsigned ref_tab [16];

    fg_design dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .N     (N),
        .FACT  (FACT),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned full_fact(input int n);
        longint unsigned f = 1;
        for (int i = 2; i <= n; i++) f = f * longint'(i);
        return f;
    endfunction

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a request accepted at edge k completes at edge k+max(N,1).
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_fact = 32'd0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (cyc == m_end) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_fact = m_pend_fact;
                    m_ovf  = m_pend_ovf;
                end
            end else if (start) begin
                longint unsigned f;
                f = full_fact(int'(N));
                m_busy      = 1'b1;
                m_end       = cyc + ((N > 4'd1) ? int'(N) : 1);
                m_pend_fact = f[31:0];
                m_pend_ovf  = (f > 64'hFFFF_FFFF);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("done", done, m_done);
            chk("busy", busy, m_busy);
            chk("FACT", FACT, m_fact);
            chk("ovf",  ovf,  m_ovf);
            if (done === 1'b1) done_cnt++;
        end
    end

    // Pulse start for one edge; lat returns edges from acceptance to done.
    task automatic run_op(input logic [3:0] n, output logic [31:0] f, output logic o,
                          output int lat);
        start = 1'b1;
        N     = n;
        @(negedge clk);
        start = 1'b0;
        N     = $urandom_range(0, 15);
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        f = FACT;
        o = ovf;
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [31:0] f;
        logic        o;
        int          lat;
        int          dc;

        ref_tab[0]  = 1;          ref_tab[1]  = 1;
        ref_tab[2]  = 2;          ref_tab[3]  = 6;
        ref_tab[4]  = 24;         ref_tab[5]  = 120;
        ref_tab[6]  = 720;        ref_tab[7]  = 5040;
        ref_tab[8]  = 40320;      ref_tab[9]  = 362880;
        ref_tab[10] = 3628800;    ref_tab[11] = 39916800;
        ref_tab[12] = 479001600;  ref_tab[13] = 1932053504;
        ref_tab[14] = 1278945280; ref_tab[15] = 2004310016;

        // reset held with start asserted
        rst_n = 1'b0;
        start = 1'b1;
        N     = 4'd7;
        @(negedge clk);
        @(negedge clk);
        chk("rst_FACT", FACT, 0);
        chk("rst_ovf",  ovf,  0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // sweep 0..15 against the literal reference list and latency rule
        for (int n = 0; n < 16; n++) begin
            run_op(4'(n), f, o, lat);
            chk($sformatf("sweep_fact_%0d", n), f, ref_tab[n]);
            chk($sformatf("sweep_ovf_%0d", n),  o, (n >= 13) ? 1 : 0);
            chk($sformatf("sweep_lat_%0d", n),  lat, (n > 1) ? n : 1);
            idle(1);
        end

        // overflow boundary
        run_op(4'd12, f, o, lat);
        chk("bound12_fact", f, 479001600);
        chk("bound12_ovf",  o, 0);
        idle(1);
        run_op(4'd13, f, o, lat);
        chk("bound13_fact", f, 1932053504);
        chk("bound13_ovf",  o, 1);
        idle(1);

        // start during busy is ignored
        dc = done_cnt;
        start = 1'b1;
        N     = 4'd10;
        @(negedge clk);
        start = 1'b0;
        idle(3);
        start = 1'b1;
        N     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        idle(25);
        chk("rej_done_count", done_cnt - dc, 1);
        chk("rej_fact", FACT, 3628800);

        // reset mid-computation
        start = 1'b1;
        N     = 4'd15;
        @(negedge clk);
        start = 1'b0;
        idle(6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_FACT", FACT, 0);
        chk("midrst_ovf",  ovf,  0);
        rst_n = 1'b1;
        dc = done_cnt;
        idle(20);
        chk("midrst_no_done", done_cnt - dc, 0);
        run_op(4'd4, f, o, lat);
        chk("after_rst_fact", f, 24);

        // back-to-back: new start on the done cycle
        idle(2);
        run_op(4'd6, f, o, lat);
        chk("b2b_first", f, 720);
        run_op(4'd3, f, o, lat);
        chk("b2b_second", f, 6);
        chk("b2b_lat", lat, 3);

        // randomized traffic; the per-cycle model check does the work
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            N     = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 99) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        start = 1'b0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
